// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic front end: feeder FSM states and the
// feed-length helper used by both the scheduler and the activation feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } feeder_state_e;

    // Clocks spent driving one skewed matrix: 2N-1 steps of step_cycles each.
    function automatic int feed_cycles(input int matrix_size, input int step_cycles);
        return (2 * matrix_size - 1) * step_cycles;
    endfunction

endpackage

// File: rtl/activation_feeder_if.sv
// Row-vector valid/ready load channel into the activation feeder.
// master = upstream producer, slave = feeder.
interface activation_feeder_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
);
    logic                             in_valid;
    logic                             in_ready;
    logic [MATRIX_SIZE*DATA_SIZE-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/activation_feeder_buffer.sv
// N x N activation register file: one full-row write port and a combinational
// diagonal read (lane r sees row step-r, column r, with an in-range flag).
module feeder_buffer #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int ROW_W       = 2,
    parameter int STEP_W      = 2
) (
    input  logic                             clk,
    input  logic                             wr_en_i,
    input  logic [ROW_W-1:0]                 wr_row_i,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] wr_data_i,
    input  logic [STEP_W-1:0]                step_i,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] diag_data_o,
    output logic [MATRIX_SIZE-1:0]           diag_valid_o
);

    logic [DATA_SIZE-1:0] mem_q [MATRIX_SIZE][MATRIX_SIZE];

    always_ff @(posedge clk) begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (wr_en_i && (int'(wr_row_i) == i)) begin
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    mem_q[i][j] <= wr_data_i[j*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    // The row being written this cycle is forwarded so the first feed step can
    // read the final beat on the same edge it lands (matters when N == 1).
    always_comb begin
        diag_data_o  = '0;
        diag_valid_o = '0;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                if ((int'(step_i) - r) == i) begin
                    diag_valid_o[r] = 1'b1;
                    if (wr_en_i && (int'(wr_row_i) == i)) begin
                        diag_data_o[r*DATA_SIZE +: DATA_SIZE] = wr_data_i[r*DATA_SIZE +: DATA_SIZE];
                    end else begin
                        diag_data_o[r*DATA_SIZE +: DATA_SIZE] = mem_q[i][r];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/activation_feeder.sv
// Loads one N x N activation matrix over valid/ready and feeds it diagonally
// skewed into the PE array. Optional upstream-stall counter: FEEDER_STALL_CNT_EN.
module activation_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int STEP_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             general_enable,
    input  logic                             start,
    activation_feeder_if.slave               in_if,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] a_out,
    output logic [MATRIX_SIZE-1:0]           a_valid,
    output logic                             busy,
    output logic                             done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_count
`endif
);

    localparam int BEAT_W = $clog2(MATRIX_SIZE + 1);
    localparam int STEP_W = $clog2(2 * MATRIX_SIZE);
    localparam int CYC_W  = $clog2(STEP_CYCLES + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MATRIX_SIZE - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * MATRIX_SIZE - 2);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(STEP_CYCLES - 1);

    feeder_state_e                    state_q, state_d;
    logic [BEAT_W-1:0]                beat_cnt_q, beat_cnt_d;
    logic [STEP_W-1:0]                step_cnt_q, step_cnt_d;
    logic [CYC_W-1:0]                 cyc_cnt_q, cyc_cnt_d;
    logic [MATRIX_SIZE*DATA_SIZE-1:0] a_out_q, a_out_d;
    logic [MATRIX_SIZE-1:0]           a_valid_q, a_valid_d;

    logic                             accept;
    logic [MATRIX_SIZE*DATA_SIZE-1:0] diag_data;
    logic [MATRIX_SIZE-1:0]           diag_valid;

    assign in_if.in_ready = (state_q == LOAD) && general_enable;
    assign accept         = in_if.in_valid && in_if.in_ready;

    feeder_buffer #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .ROW_W       (BEAT_W),
        .STEP_W      (STEP_W)
    ) u_buffer (
        .clk          (clk),
        .wr_en_i      (accept),
        .wr_row_i     (beat_cnt_q),
        .wr_data_i    (in_if.in_data),
        .step_i       (step_cnt_d),
        .diag_data_o  (diag_data),
        .diag_valid_o (diag_valid)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        step_cnt_d = step_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    beat_cnt_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = FEED;
                        step_cnt_d = '0;
                        cyc_cnt_d  = '0;
                    end
                end
            end
            FEED: begin
                if (cyc_cnt_q == LAST_CYC) begin
                    cyc_cnt_d = '0;
                    if (step_cnt_q == LAST_STEP) begin
                        state_d = DONE;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next step so they line up with FEED entry.
    always_comb begin
        a_out_d   = '0;
        a_valid_d = '0;
        if (state_d == FEED) begin
            a_out_d   = diag_data;
            a_valid_d = diag_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            step_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            a_out_q    <= '0;
            a_valid_q  <= '0;
        end else if (general_enable) begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            step_cnt_q <= step_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            a_out_q    <= a_out_d;
            a_valid_q  <= a_valid_d;
        end
    end

    assign a_out   = a_out_q;
    assign a_valid = a_valid_q;
    assign busy    = (state_q == LOAD) || (state_q == FEED);
    assign done    = (state_q == DONE);

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if ((state_q == LOAD) && !in_if.in_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (general_enable) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/activation_feeder.md
Name: activation_feeder

Overview:
- Sits directly upstream of the systolic PE array, alongside the scheduler.
- Buffers one MATRIX_SIZE x MATRIX_SIZE activation matrix, received one row-vector per valid/ready beat.
- Drives it into the array's left edge with diagonal skew: lane r is delayed r steps.
- Each step lasts STEP_CYCLES clocks, matching the scheduler's 4-cycle row-enable cadence. The feed runs 2N-1 steps, then done pulses.

Parameters:
- MATRIX_SIZE, 2, N: array dimension, number of lanes and number of beats per matrix.
- DATA_SIZE, 32, width of one activation element.
- STEP_CYCLES, 4, clocks each skew step is held; must be >= 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- general_enable  in  1  when low, all state and outputs hold (global stall).
- start  in  1  begin a matrix load; sampled only in IDLE.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  feeder accepts a beat.
- in_data  in  MATRIX_SIZE*DATA_SIZE  one matrix row; element j is in_data[j*DATA_SIZE +: DATA_SIZE].
- a_out  out  MATRIX_SIZE*DATA_SIZE  skewed activations; lane r is a_out[r*DATA_SIZE +: DATA_SIZE].
- a_valid  out  MATRIX_SIZE  per-lane valid.
- busy  out  1  high in LOAD or FEED.
- done  out  1  one-cycle pulse after the last feed step.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; beat_cnt=0, step_cnt=0, cyc_cnt=0.
  - Outputs: a_out=0, a_valid=0, in_ready=0, busy=0, done=0.
  - Buffer contents are don't-care.
  - Reset overrides general_enable and aborts any load or feed in progress.
- general_enable==0: no state, counter, buffer or output register changes. in_ready is forced to 0, so no handshake occurs.
- FSM: IDLE -> LOAD -> FEED -> DONE -> IDLE.
  - IDLE: start==1 -> LOAD next cycle. start in any other state is ignored.
  - LOAD: in_ready=1. A beat is accepted when in_valid & in_ready: in_data is written to buffer row beat_cnt, and beat_cnt increments. The beat with beat_cnt==N-1 moves to FEED next cycle with step_cnt=0, cyc_cnt=0. Cycles with in_valid low simply wait; there is no timeout.
  - FEED:
    - Registered outputs: for step s=step_cnt, lane r drives buffer[s-r][r] with a_valid[r]=1 when 0<=s-r<N; otherwise a_out lane=0 and a_valid[r]=0.
    - The step-0 outputs appear on the first FEED cycle, one cycle after the last load handshake.
    - cyc_cnt counts 0..STEP_CYCLES-1. On wrap, step_cnt increments.
    - After step 2N-2 completes, go to DONE.
    - Total FEED duration: (2N-1)*STEP_CYCLES cycles.
  - DONE: done=1 for exactly one cycle; a_out=0, a_valid=0; next state IDLE. A start asserted during DONE is ignored.
- in_ready is 0 in IDLE, FEED and DONE.
- busy = (state==LOAD || state==FEED).
- Counter widths: beat_cnt $clog2(N+1); step_cnt $clog2(2N); cyc_cnt $clog2(STEP_CYCLES+1). No overflow is reachable.
- N=1: one beat, one step; lane 0 valid for STEP_CYCLES cycles.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_count (16 bits).
  - Counts cycles in LOAD with general_enable==1 and in_valid==0.
  - Saturates at 16'hFFFF.
  - Clears on start acceptance and on reset.
  - Holds its value through FEED, DONE and IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package systolic_pkg:
  - typedef for the FSM state enum (IDLE, LOAD, FEED, DONE).
  - Localparam helper for feed length, (2*MATRIX_SIZE-1)*STEP_CYCLES, so scheduler and feeder agree.
- One natural sub-module: feeder_buffer, an N x N register file with a row-write port and a combinational per-lane diagonal read (row index s-r, column r, in-range flag).
- FSM and counters stay in activation_feeder.

Test Plan:
- Basic skew: N=2, STEP_CYCLES=4; start; beats {a00=1,a01=2}, then {a10=3,a11=4} back-to-back. Required response:
  - Cycles 0-3 of FEED: lane0=1 v=1; lane1=0 v=0.
  - Cycles 4-7: lane0=3, lane1=2, both valid.
  - Cycles 8-11: lane0 invalid, lane1=4.
  - Next cycle done=1 for one cycle; busy is low after it.
- Upstream stall: in_valid low for 3 cycles between beats -> load completes 3 cycles later and skew outputs are unchanged. With FEEDER_STALL_CNT_EN, stall_count=3.
- Global stall mid-FEED: drop general_enable for 5 cycles during step 1 -> a_out/a_valid frozen; FEED total stretches to 17 cycles; data sequence unchanged.
- Reset mid-operation: reset=0 during FEED step 1 -> next cycle a_out=0, a_valid=0, busy=0, done=0. A new start then runs a full, correct load and feed.
- Ignored start: pulse start during LOAD, FEED and DONE -> no state change; exactly one done pulse per matrix.
- Back-to-back matrices: start asserted the cycle after done -> a second correct feed, with no lane carrying data from the first matrix.
